ccff_bitstream_loader: RTL and testbench



---
 rtl/ccff_loader_pkg.sv | 15 +
 rtl/ccff_piso.sv | 27 ++
 rtl/ccff_bitstream_loader.sv | 121 ++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain bitstream loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccff_piso.sv
// Parallel-load, MSB-first shift register feeding the config chain.
module ccff_piso #(
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic              msb
);

  logic [WORD_W-1:0] shreg;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= shreg << 1;
    end
  end

  assign msb = shreg[WORD_W-1];

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words onto ccff_head, stopping after CHAIN_LEN bits.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 36
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = cnt_width(CHAIN_LEN);
  localparam int WB_W  = cnt_width(WORD_W);

  state_e            state;
  state_e            state_nx;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WB_W-1:0]   word_bits;
  logic              load;
  logic              shift;
  logic              clr;
  logic              last_bit;
  logic              last_word_bit;
  logic              piso_msb;

  assign last_bit      = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign last_word_bit = (word_bits == WB_W'(WORD_W - 1));

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    shift    = 1'b0;
    clr      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = FETCH;
          clr      = 1'b1;
        end
      end
      FETCH: begin
        if (cfg_valid) begin
          state_nx = SHIFT;
          load     = 1'b1;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        // Chain length wins over word boundary: padding bits are dropped
        if (last_bit) begin
          state_nx = DONE;
        end else if (last_word_bit) begin
          state_nx = FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      bit_cnt   <= '0;
      word_bits <= '0;
    end else begin
      if (clr) begin
        bit_cnt <= '0;
      end else if (shift) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (load) begin
        word_bits <= '0;
      end else if (shift) begin
        word_bits <= word_bits + 1'b1;
      end
    end
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
    end else begin
      ccff_shift_en <= shift;
      if (shift) begin
        ccff_head <= piso_msb;
      end
    end
  end

  ccff_piso #(
    .WORD_W(WORD_W)
  ) u_piso (
    .prog_clk(prog_clk),
    .pReset_n(pReset_n),
    .load    (load),
    .shift   (shift),
    .din     (cfg_data),
    .msb     (piso_msb)
  );

  assign cfg_ready = (state == FETCH);
  assign busy      = (state == FETCH) || (state == SHIFT);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader (36-bit and 1-bit chains).
module tb_ccff_bitstream_loader;

  logic       prog_clk = 1'b0;
  logic       pReset_n;
  logic       start;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       ccff_head;
  logic       ccff_shift_en;
  logic       busy;
  logic       done;

  logic       start1;
  logic [7:0] cfg_data1;
  logic       cfg_valid1;
  logic       cfg_ready1;
  logic       ccff_head1;
  logic       ccff_shift_en1;
  logic       busy1;
  logic       done1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 prog_clk = ~prog_clk;

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(36)) u_dut (
    .prog_clk     (prog_clk),
    .pReset_n     (pReset_n),
    .start        (start),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .busy         (busy),
    .done         (done)
  );

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(1)) u_dut1 (
    .prog_clk     (prog_clk),
    .pReset_n     (pReset_n),
    .start        (start1),
    .cfg_data     (cfg_data1),
    .cfg_valid    (cfg_valid1),
    .cfg_ready    (cfg_ready1),
    .ccff_head    (ccff_head1),
    .ccff_shift_en(ccff_shift_en1),
    .busy         (busy1),
    .done         (done1)
  );

  // Downstream chain: chain[0] is the flop at ccff_head
  logic [35:0] chain;
  always @(posedge prog_clk) begin
    if (ccff_shift_en) chain <= {chain[34:0], ccff_head};
  end

  logic [7:0] words[$];
  bit         bits[$];
  int         hs;
  int         busy_cycles;
  int         fetch_idle;
  int         extra_en;
  int         ready_after_done;
  bit         timeout;
  bit         done_early;
  bit         done_on_last;
  logic [4:0] snap;

  function automatic logic [35:0] exp_stream();
    logic [39:0] v;
    v = {words[0], words[1], words[2], words[3], words[4]};
    return v[39:4];
  endfunction

  function automatic logic [35:0] got_stream();
    logic [35:0] g;
    g = '0;
    for (int k = 0; k < bits.size() && k < 36; k++) g[35-k] = bits[k];
    return g;
  endfunction

  task automatic run_load(input int stall_before, input int stall_len,
                          input int restart_at, input int abort_at);
    int  wi;
    int  stalled;
    bit  fin;
    bit  aborted;
    wi = 0; stalled = 0; fin = 0; aborted = 0;
    bits.delete();
    hs = 0; busy_cycles = 0; fetch_idle = 0; extra_en = 0;
    ready_after_done = 0; timeout = 0; done_early = 0; done_on_last = 0;
    @(negedge prog_clk);
    start = 1'b1; cfg_valid = 1'b0;
    @(negedge prog_clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (ccff_shift_en) begin
        bits.push_back(ccff_head);
        if (bits.size() == 36) done_on_last = done;
      end
      if (done) begin
        if (bits.size() < 36) done_early = 1;
        fin = 1;
        break;
      end
      if (busy) busy_cycles++;
      if (cfg_ready && !ccff_shift_en) fetch_idle++;
      if (abort_at > 0 && bits.size() == abort_at) begin
        pReset_n = 1'b0;
        #1;
        snap = {cfg_ready, ccff_head, ccff_shift_en, busy, done};
        aborted = 1;
        fin = 1;
        break;
      end
      start = (restart_at > 0 && bits.size() == restart_at);
      if (wi < words.size() &&
          !(wi == stall_before && stalled < stall_len && cfg_ready)) begin
        cfg_valid = 1'b1;
        cfg_data  = words[wi];
        if (cfg_ready) begin hs++; wi++; end
      end else begin
        cfg_valid = 1'b0;
        if (wi == stall_before && cfg_ready) stalled++;
      end
      @(negedge prog_clk);
    end
    start = 1'b0;
    if (!fin) timeout = 1;
    if (!aborted) begin
      for (int t = 0; t < 4; t++) begin
        @(negedge prog_clk);
        if (ccff_shift_en) extra_en++;
        if (cfg_ready) ready_after_done++;
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_checks++;
    if ({cfg_ready, ccff_head, ccff_shift_en, busy, done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {cfg_ready, ccff_head, ccff_shift_en, busy, done});
    end
    n_checks++;
    if ({cfg_ready1, ccff_head1, ccff_shift_en1, busy1, done1} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_len1: got %b expected 00000",
               {cfg_ready1, ccff_head1, ccff_shift_en1, busy1, done1});
    end
    @(negedge prog_clk);
    pReset_n = 1'b1;
  endtask

  task automatic test_stream;
    words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h90, 8'h77};
    run_load(-1, 0, 0, 0);
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++; $display("FAIL stream_timeout: got %0d expected 0", timeout);
    end
    n_checks++;
    if (bits.size() != 36) begin
      n_fail++; $display("FAIL stream_len: got %0d expected 36", bits.size());
    end
    n_checks++;
    if (got_stream() !== 36'hA53CFF009) begin
      n_fail++;
      $display("FAIL stream_bits: got %h expected a53cff009", got_stream());
    end
    n_checks++;
    if (hs != 5) begin
      n_fail++; $display("FAIL stream_handshakes: got %0d expected 5", hs);
    end
    n_checks++;
    if (!done_on_last || done_early) begin
      n_fail++;
      $display("FAIL stream_done_timing: got last=%0d early=%0d expected 1 0",
               done_on_last, done_early);
    end
    n_checks++;
    if (busy_cycles != 41) begin
      n_fail++; $display("FAIL stream_cycles: got %0d expected 41", busy_cycles);
    end
    n_checks++;
    if (fetch_idle != 1) begin
      n_fail++; $display("FAIL stream_fetch_idle: got %0d expected 1", fetch_idle);
    end
    n_checks++;
    if (extra_en != 0 || ready_after_done != 0) begin
      n_fail++;
      $display("FAIL stream_after_done: got en=%0d rdy=%0d expected 0 0",
               extra_en, ready_after_done);
    end
  endtask

  task automatic test_stall;
    words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h90, 8'h77};
    run_load(2, 3, 0, 0);
    n_checks++;
    if (timeout || got_stream() !== 36'hA53CFF009 || bits.size() != 36) begin
      n_fail++;
      $display("FAIL stall_bits: got %h n=%0d expected a53cff009 n=36",
               got_stream(), bits.size());
    end
    n_checks++;
    if (fetch_idle != 4) begin
      n_fail++; $display("FAIL stall_fetch_idle: got %0d expected 4", fetch_idle);
    end
    n_checks++;
    if (busy_cycles != 44) begin
      n_fail++; $display("FAIL stall_cycles: got %0d expected 44", busy_cycles);
    end
    n_checks++;
    if (hs != 5) begin
      n_fail++; $display("FAIL stall_handshakes: got %0d expected 5", hs);
    end
  endtask

  task automatic test_start_busy;
    words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h90, 8'h77};
    run_load(-1, 0, 10, 0);
    n_checks++;
    if (timeout || bits.size() != 36 || got_stream() !== 36'hA53CFF009) begin
      n_fail++;
      $display("FAIL start_busy_bits: got %h n=%0d expected a53cff009 n=36",
               got_stream(), bits.size());
    end
    n_checks++;
    if (busy_cycles != 41 || hs != 5) begin
      n_fail++;
      $display("FAIL start_busy_cycles: got %0d hs=%0d expected 41 hs=5",
               busy_cycles, hs);
    end
  endtask

  task automatic test_reset_mid;
    words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h90, 8'h77};
    run_load(-1, 0, 0, 13);
    n_checks++;
    if (bits.size() != 13 || snap !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %b n=%0d expected 00000 n=13",
               snap, bits.size());
    end
    @(negedge prog_clk);
    pReset_n = 1'b1;
    words = '{8'h5A, 8'hC3, 8'h01, 8'h80, 8'h6F, 8'hEE};
    run_load(-1, 0, 0, 0);
    n_checks++;
    if (timeout || bits.size() != 36 || got_stream() !== 36'h5AC301806) begin
      n_fail++;
      $display("FAIL reset_mid_reload: got %h n=%0d expected 5ac301806 n=36",
               got_stream(), bits.size());
    end
  endtask

  task automatic test_chain1;
    logic [7:0] d [2];
    logic       e [2];
    d[0] = 8'h80; d[1] = 8'h40;
    e[0] = 1'b1;  e[1] = 1'b0;
    for (int r = 0; r < 2; r++) begin
      int   nb;
      int   nh;
      int   extra;
      logic hb;
      bit   ok;
      nb = 0; nh = 0; extra = 0; hb = 1'bx; ok = 0;
      @(negedge prog_clk);
      start1 = 1'b1; cfg_valid1 = 1'b0;
      @(negedge prog_clk);
      start1 = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (ccff_shift_en1) begin nb++; hb = ccff_head1; end
        if (done1) begin ok = 1; break; end
        cfg_valid1 = 1'b1;
        cfg_data1  = d[r];
        if (cfg_ready1) nh++;
        @(negedge prog_clk);
      end
      for (int t = 0; t < 3; t++) begin
        @(negedge prog_clk);
        if (ccff_shift_en1 || cfg_ready1) extra++;
      end
      cfg_valid1 = 1'b0;
      n_checks++;
      if (!ok || nb != 1 || hb !== e[r]) begin
        n_fail++;
        $display("FAIL chain1_load%0d: got done=%0d n=%0d head=%b expected 1 1 %b",
                 r, ok, nb, hb, e[r]);
      end
      n_checks++;
      if (nh != 1 || extra != 0) begin
        n_fail++;
        $display("FAIL chain1_hs%0d: got hs=%0d extra=%0d expected 1 0",
                 r, nh, extra);
      end
    end
  endtask

  task automatic test_chain_model;
    words.delete();
    for (int i = 0; i < 6; i++) words.push_back(8'($urandom));
    run_load(-1, 0, 0, 0);
    n_checks++;
    if (timeout || chain !== exp_stream()) begin
      n_fail++;
      $display("FAIL chain_contents: got %h expected %h", chain, exp_stream());
    end
    n_checks++;
    if (got_stream() !== exp_stream() || bits.size() != 36) begin
      n_fail++;
      $display("FAIL chain_stream: got %h n=%0d expected %h n=36",
               got_stream(), bits.size(), exp_stream());
    end
  endtask

  initial begin
    pReset_n   = 1'b0;
    start      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_data   = '0;
    start1     = 1'b0;
    cfg_valid1 = 1'b0;
    cfg_data1  = '0;
    test_reset();
    test_stream();
    test_stall();
    test_start_busy();
    test_reset_mid();
    test_chain1();
    test_chain_model();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
